// File: rtl/alu_op_issuer.sv
// alu_op_issuer: initiator side of the ALU datapath interface.
// Accepts one operation at a time over req_valid/req_ready and drives the ALU
// operands and control code from registers. It captures the ALU result and
// zero flag, then returns them over rsp_valid/rsp_ready.
// Ports:
//   clk, reset_b           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_in1, req_in2, req_ctrl payload
//   rsp_valid/rsp_ready    response handshake; rsp_result, rsp_zero, rsp_illegal payload
//   alu_in1/in2/control    registered drive to the combinational ALU
//   alu_result/alu_zero    ALU outputs, captured one cycle after a legal accept
//   op_count               completed responses, wraps modulo 2^CNT_WIDTH
module alu_op_issuer #(
  parameter int unsigned REG_WIDTH = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_WIDTH-1:0] req_in1,
  input  logic [REG_WIDTH-1:0] req_in2,
  input  logic [3:0]           req_ctrl,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_illegal,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_control,
  input  logic [REG_WIDTH-1:0] alu_result,
  input  logic                 alu_zero,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [REG_WIDTH-1:0] r_rsp_result;
  logic                 r_rsp_zero;
  logic                 r_rsp_illegal;
  logic [REG_WIDTH-1:0] r_alu_in1;
  logic [REG_WIDTH-1:0] r_alu_in2;
  logic [3:0]           r_alu_control;
  logic [CNT_WIDTH-1:0] r_op_count;
  logic                 w_legal;
  logic                 w_accept;
  logic                 w_rsp_hs;

  // Supported codes: AND, OR, ADD, SUB
  always_comb begin
    w_legal = 1'b0;
    case (req_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = w_legal ? S_EXEC : S_RESP;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake flags are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
    end
  end

  // Operand drive, response capture and completion counter
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_alu_in1     <= '0;
      r_alu_in2     <= '0;
      r_alu_control <= 4'd0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_op_count    <= '0;
    end else begin
      if (w_accept) begin
        if (w_legal) begin
          r_alu_in1     <= req_in1;
          r_alu_in2     <= req_in2;
          r_alu_control <= req_ctrl;
        end else begin
          // Illegal code never reaches the ALU; the ALU drive keeps its last value
          r_rsp_result  <= '0;
          r_rsp_zero    <= 1'b0;
          r_rsp_illegal <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        r_rsp_result  <= alu_result;
        r_rsp_zero    <= alu_zero;
        r_rsp_illegal <= 1'b0;
      end
      if (w_rsp_hs) r_op_count <= r_op_count + CNT_WIDTH'(1);
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_illegal = r_rsp_illegal;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_control = r_alu_control;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: exercises alu_op_issuer with a behavioural ALU attached.
// Expected responses are computed from the request operands with plain arithmetic.
module tb_alu_op_issuer;

  localparam int unsigned RW    = 64;
  localparam int unsigned CNT_W = 4;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_in1;
  logic [RW-1:0] req_in2;
  logic [3:0]    req_ctrl;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_illegal;
  logic [RW-1:0] alu_in1;
  logic [RW-1:0] alu_in2;
  logic [3:0]    alu_control;
  logic [RW-1:0] alu_result;
  logic          alu_zero;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  // Reference state: completed ops and last legal request seen by the ALU
  int            exp_count;
  logic [RW-1:0] sh_in1;
  logic [RW-1:0] sh_in2;
  logic [3:0]    sh_ctrl;

  always #5 clk = ~clk;

  alu_op_issuer #(.REG_WIDTH(RW), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .op_count(op_count)
  );

  function automatic logic [RW-1:0] alu_fn(input logic [3:0] c, input logic [RW-1:0] a,
                                           input logic [RW-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0110);
  endfunction

  function automatic logic [RW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] rnd_legal();
    logic [3:0] tbl [4];
    tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0010; tbl[3] = 4'b0110;
    return tbl[$urandom_range(0, 3)];
  endfunction

  // Combinational ALU model driven by the issuer's registered outputs
  always_comb begin
    alu_result = alu_fn(alu_control, alu_in1, alu_in2);
    alu_zero   = (alu_result == '0);
  end

  // Issue one request, hold the response for 'hold' cycles, then complete it
  task automatic do_op(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [3:0] c,
                       input int hold, input bit intrude);
    logic [RW-1:0] exp_res;
    logic          exp_zero;
    bit            legal;
    legal = is_legal(c);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got=%b exp=1", req_ready); end
    req_in1 = a; req_in2 = b; req_ctrl = c; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_in1 = rnd64(); req_in2 = rnd64(); req_ctrl = 4'($urandom);
    if (legal) begin
      sh_in1 = a; sh_in2 = b; sh_ctrl = c;
      exp_res  = alu_fn(c, a, b);
      exp_zero = (exp_res == '0);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_valid_exec got=%b exp=0", rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_exec got=%b exp=0", req_ready); end
      @(negedge clk);
    end else begin
      exp_res  = '0;
      exp_zero = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid_resp got=%b exp=1", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_resp got=%b exp=0", req_ready); end
    checks++; if (rsp_result !== exp_res) begin errors++; $display("FAIL rsp_result ctrl=%b got=%h exp=%h", c, rsp_result, exp_res); end
    checks++; if (rsp_zero !== exp_zero) begin errors++; $display("FAIL rsp_zero got=%b exp=%b", rsp_zero, exp_zero); end
    checks++; if (rsp_illegal !== !legal) begin errors++; $display("FAIL rsp_illegal got=%b exp=%b", rsp_illegal, !legal); end
    checks++; if ({alu_in1, alu_in2, alu_control} !== {sh_in1, sh_in2, sh_ctrl}) begin
      errors++; $display("FAIL alu_drive got=%h/%h/%b exp=%h/%h/%b", alu_in1, alu_in2, alu_control, sh_in1, sh_in2, sh_ctrl);
    end
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin
        req_valid = 1'b1; req_in1 = rnd64(); req_in2 = rnd64(); req_ctrl = rnd_legal();
      end
      @(negedge clk);
      checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL hold_flags got=%b%b exp=10", rsp_valid, req_ready); end
      checks++; if ({rsp_result, rsp_zero, rsp_illegal} !== {exp_res, exp_zero, !legal}) begin
        errors++; $display("FAIL hold_payload got=%h/%b/%b exp=%h/%b/%b", rsp_result, rsp_zero, rsp_illegal, exp_res, exp_zero, !legal);
      end
      checks++; if (alu_in1 !== sh_in1 || alu_control !== sh_ctrl) begin
        errors++; $display("FAIL hold_alu got=%h/%b exp=%h/%b", alu_in1, alu_control, sh_in1, sh_ctrl);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL after_hs got=%b%b exp=01", rsp_valid, req_ready); end
    checks++; if (op_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL op_count got=%0d exp=%0d", op_count, CNT_W'(exp_count)); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_b = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    exp_count = 0; sh_in1 = '0; sh_in2 = '0; sh_ctrl = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL reset_flags got=%b%b exp=10", req_ready, rsp_valid); end
    checks++; if ({alu_in1, alu_in2, alu_control, rsp_result, rsp_zero, rsp_illegal} !== '0 || op_count !== '0) begin
      errors++; $display("FAIL reset_regs alu=%h/%h/%b rsp=%h/%b/%b cnt=%0d exp all 0", alu_in1, alu_in2, alu_control, rsp_result, rsp_zero, rsp_illegal, op_count);
    end
  endtask

  task automatic test_add();
    do_op(64'd8, 64'd4, 4'b0010, 0, 1'b0);
    checks++; if (rsp_result !== 64'd12 || alu_control !== 4'b0010 || op_count !== CNT_W'(1)) begin
      errors++; $display("FAIL add_result got=%0d/%b/%0d exp=12/0010/1", rsp_result, alu_control, op_count);
    end
  endtask

  task automatic test_illegal();
    do_op(64'd5, 64'd9, 4'b0111, 0, 1'b0);
    checks++; if (alu_control !== 4'b0010) begin errors++; $display("FAIL illegal_keeps_ctrl got=%b exp=0010", alu_control); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_op(64'd8, 64'd4, 4'b0110, 0, 1'b0);
    do_op(64'd8, 64'd4, 4'b0000, 0, 1'b0);
    do_op(64'd8, 64'd4, 4'b0001, 0, 1'b0);
    do_op(64'd8, 64'd8, 4'b0110, 0, 1'b0);
    checks++; if (op_count !== CNT_W'(4)) begin errors++; $display("FAIL b2b_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_backpressure();
    do_op(64'd8, 64'd4, 4'b0010, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_in1 = 64'd3; req_in2 = 64'd1; req_ctrl = 4'b0010; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_b = 1'b0;
    exp_count = 0; sh_in1 = '0; sh_in2 = '0; sh_ctrl = 4'd0;
    #1;
    checks++; if ({req_ready, rsp_valid, alu_in1, alu_control, rsp_result, op_count} !== {1'b1, 1'b0, 64'd0, 4'd0, 64'd0, 4'd0}) begin
      errors++; $display("FAIL mid_reset rdy=%b vld=%b in1=%h ctl=%b res=%h cnt=%0d exp 1/0/0/0/0/0", req_ready, rsp_valid, alu_in1, alu_control, rsp_result, op_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) reset_b = 1'b1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp got=%b exp=0", rsp_valid); end
    end
    do_op(64'd8, 64'd8, 4'b0110, 0, 1'b0);
    checks++; if (rsp_result !== 64'd0 || op_count !== CNT_W'(1)) begin
      errors++; $display("FAIL after_mid_reset got=%0d/%0d exp=0/1", rsp_result, op_count);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] c;
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : rnd_legal();
      do_op(rnd64(), rnd64(), c, 0, 1'b0);
      if (i == 15) begin checks++; if (op_count !== 4'd15) begin errors++; $display("FAIL wrap15 got=%0d exp=15", op_count); end end
      if (i == 16) begin checks++; if (op_count !== 4'd0)  begin errors++; $display("FAIL wrap16 got=%0d exp=0", op_count); end end
      if (i == 17) begin checks++; if (op_count !== 4'd1)  begin errors++; $display("FAIL wrap17 got=%0d exp=1", op_count); end end
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [3:0]    c;
    for (int i = 0; i < 30; i++) begin
      a = rnd64();
      b = ($urandom_range(0, 3) == 0) ? a : rnd64();
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : rnd_legal();
      do_op(a, b, c, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    reset_b = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_in1 = '0; req_in2 = '0; req_ctrl = 4'd0;
    test_reset();
    test_add();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator side of the ALU datapath interface: accepts operation requests over a valid/ready handshake, drives the ALU operand and control lines from registers, captures result and zero flag, and returns them over a response valid/ready handshake.
- Sits between the control/sequencing logic and the combinational ALU (64-bit operands, 4-bit alu_control, result, zero).
- Only one operation is in flight at a time.

Parameters:
- REG_WIDTH, 64, operand/result width; equals register-file width.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  issuer can accept a request.
- req_in1  input  REG_WIDTH  operand 1.
- req_in2  input  REG_WIDTH  operand 2.
- req_ctrl  input  4  ALU control code.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  REG_WIDTH  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.
- rsp_illegal  output  1  request carried an unsupported control code.
- alu_in1  output  REG_WIDTH  registered operand 1 driven to the ALU.
- alu_in2  output  REG_WIDTH  registered operand 2 driven to the ALU.
- alu_control  output  4  registered control code driven to the ALU.
- alu_result  input  REG_WIDTH  ALU result (combinational from alu_* outputs).
- alu_zero  input  1  ALU zero flag.
- op_count  output  CNT_WIDTH  number of completed responses.

Behaviour:
- Reset (reset_b low, asynchronous):
  - State goes to IDLE.
  - All registered outputs clear to 0: alu_in1, alu_in2, alu_control, rsp_result, rsp_zero, rsp_illegal, rsp_valid, op_count.
  - req_ready = 1, since it is decoded from IDLE.
- Legal codes: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB. Every other code is illegal.
- States and transitions:
  - IDLE: req_ready=1, rsp_valid=0. On req_valid at an edge:
    - Legal code: load alu_in1/alu_in2/alu_control from the request, go to EXEC.
    - Illegal code: leave the alu_* registers unchanged, set rsp_result=0, rsp_zero=0, rsp_illegal=1, go to RESP.
  - EXEC: req_ready=0. Exactly one cycle. At the next edge capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_illegal=0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready at an edge: op_count += 1, go to IDLE.
- Latency, counted from the accept edge E0:
  - Legal request: rsp_valid is high after E1. Earliest response handshake is at E1+1 cycle. req_ready returns after that handshake edge.
  - Illegal request: rsp_valid is high after E0.
  - Peak throughput is one legal op per 3 cycles and one illegal op per 2 cycles.
- Handshake rules:
  - Request fields are sampled only on the edge where req_valid && req_ready.
  - req_* values outside that edge are don't-care.
  - req_ready does not depend combinationally on req_valid.
- Response rules:
  - While rsp_valid && !rsp_ready, rsp_result, rsp_zero and rsp_illegal are held stable.
  - No response is dropped or duplicated.
- ALU drive:
  - alu_* outputs change only on the accept edge of a legal request.
  - Otherwise they hold their last value, including across illegal requests and idle periods.
- op_count:
  - Counts both legal and illegal completions.
  - Wraps modulo 2^CNT_WIDTH with no saturation and no flag.
- rsp_zero: a registered copy of the ALU flag; it is not recomputed locally.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, all outputs take reset values, and the first request after release is accepted normally.
- req_valid asserted while not IDLE: ignored; the requester must hold it until req_ready is seen.

Test Plan:
- ADD, in1=8, in2=4, ctrl=0010, rsp_ready=1 -> rsp_valid two edges after accept; rsp_result=12, rsp_zero=0, rsp_illegal=0; alu_control=0010; op_count=1.
- SUB then AND, back-to-back:
  - SUB 8,4 (0110) -> 4, zero=0.
  - AND 8,4 (0000) -> 0, zero=1.
  - OR 8,4 (0001) -> 12.
  - SUB 8,8 -> 0, zero=1.
  - After all four, op_count=4.
- Illegal ctrl=0111 after the ADD -> rsp_valid one edge after accept; rsp_illegal=1, rsp_result=0; alu_control stays 0010; op_count increments.
- Backpressure: hold rsp_ready=0 for 5 cycles after ADD 8,4 -> rsp_valid stays 1 and rsp_result stays 12 throughout, req_ready stays 0, and a request presented meanwhile is not accepted; raise rsp_ready -> one handshake, then req_ready=1.
- Reset mid-op: assert reset_b=0 in EXEC -> outputs clear immediately, no response ever; after release, SUB 8,8 completes normally with op_count=1.
- Counter wrap: with CNT_WIDTH=4, complete 17 ops -> op_count reads 15 after the 15th op, 0 after the 16th, 1 after the 17th.
